// File: rtl/cpu_types_pkg.sv
// Shared CPU control types: hazard-unit state encoding and register-0 helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      HALT  = 2'd2
   } hzd_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // A load in EX collides with the ID instruction if it writes a real
   // register that ID reads; rt only counts when ID actually sources it.
   function automatic logic load_use_hit(
      input logic       ex_load,
      input logic [4:0] ex_rt,
      input logic [4:0] rsel1,
      input logic [4:0] rsel2,
      input logic       rt_used
   );
      return ex_load && (ex_rt != REG_ZERO) &&
             ((ex_rt == rsel1) || (rt_used && (ex_rt == rsel2)));
   endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: per-stage write-enable/flush from hazards, cache status and halt.
// Latency: enables are combinational (same cycle); state and counters update on CLK.
// Backpressure: data-cache wait freezes PC..EX/MEM and bubbles WB; I-miss/load-use stall the front end.
module hazard_ctrl
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic [4:0]       id_rsel1,
   input  logic [4:0]       id_rsel2,
   input  logic             id_rt_used,
   input  logic             ex_cuDRE,
   input  logic [4:0]       ex_rt,
   input  logic             br_taken,
   input  logic             mem_cuDRE,
   input  logic             mem_cuDWE,
   input  logic             mem_HALT,
   output logic             pc_en,
   output logic             ifid_W,
   output logic             ifid_RST,
   output logic             idex_W,
   output logic             idex_RST,
   output logic             exmem_W,
   output logic             memwb_W,
   output logic             memwb_RST,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   hzd_state_t state, state_nxt;
   logic       mem_op;
   logic       mem_wait;
   logic       load_use;
   logic       flush_ev;
   logic       stall_ev;

   assign mem_op   = mem_cuDRE | mem_cuDWE;
   // The dhit cycle that closes a wait is treated as ordinary RUN decode.
   assign mem_wait = ((state == DWAIT) || ((state == RUN) && mem_op)) && !dhit;
   assign load_use = load_use_hit(ex_cuDRE, ex_rt, id_rsel1, id_rsel2, id_rt_used);
   assign halted   = (state == HALT);

   // State register: wait/halt tracking.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= RUN;
      else       state <= state_nxt;
   end

   // Next state: halt may not retire while the D-cache is still busy.
   always_comb begin
      state_nxt = state;
      if (state == HALT) begin
         state_nxt = HALT;
      end else if (mem_HALT && !((state == DWAIT) && !dhit)) begin
         state_nxt = HALT;
      end else if (state == RUN) begin
         if (mem_op && !dhit) state_nxt = DWAIT;
      end else if (state == DWAIT) begin
         if (dhit) state_nxt = RUN;
      end
   end

   // Enable/flush decode, first matching condition wins.
   always_comb begin
      pc_en     = 1'b1;
      ifid_W    = 1'b1;
      ifid_RST  = 1'b0;
      idex_W    = 1'b1;
      idex_RST  = 1'b0;
      exmem_W   = 1'b1;
      memwb_W   = 1'b1;
      memwb_RST = 1'b0;
      flush_ev  = 1'b0;
      if (!nRST || (state == HALT)) begin
         pc_en   = 1'b0;
         ifid_W  = 1'b0;
         idex_W  = 1'b0;
         exmem_W = 1'b0;
         memwb_W = 1'b0;
      end else if (mem_wait) begin
         pc_en     = 1'b0;
         ifid_W    = 1'b0;
         idex_W    = 1'b0;
         exmem_W   = 1'b0;
         memwb_RST = 1'b1;
      end else if (br_taken) begin
         // Wrong-path fetch is dropped even if ihit is low.
         ifid_RST = 1'b1;
         idex_RST = 1'b1;
         flush_ev = 1'b1;
      end else if (load_use) begin
         pc_en    = 1'b0;
         ifid_W   = 1'b0;
         idex_RST = 1'b1;
      end else if (!ihit) begin
         pc_en    = 1'b0;
         ifid_RST = 1'b1;
      end
   end

   assign stall_ev = !pc_en && (state != HALT);

   // Saturating count of cycles with the PC held.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)                             stall_cnt <= '0;
      else if (stall_ev && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
   end

   // Saturating count of taken-branch flushes.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)                             flush_cnt <= '0;
      else if (flush_ev && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit that drives the write-enable and flush inputs of every pipeline register: PC, IF/ID, ID/EX (its idW and idRST inputs), EX/MEM and MEM/WB.
- Consumes the decoded-source and execute-stage fields presented at the ID/EX boundary, plus cache hit and branch-resolution status.
- Detects the following and converts them into per-stage enable/flush pulses:
  - load-use hazards
  - data-cache waits
  - instruction-cache misses
  - taken branches/jumps
  - halt
- Holds a small wait/halt state machine and saturating stall and flush performance counters.

Parameters:
CNT_W, 16, width of stall_cnt and flush_cnt (saturating)

Ports:
CLK  in  1  clock (rising edge)
nRST  in  1  reset, asynchronous, active-low
ihit  in  1  instruction cache returned a valid word this cycle
dhit  in  1  data cache completed the MEM-stage access this cycle
id_rsel1  in  5  rs of the instruction in ID
id_rsel2  in  5  rt of the instruction in ID
id_rt_used  in  1  ID instruction reads rt as a source
ex_cuDRE  in  1  EX-stage instruction is a load
ex_rt  in  5  destination register of the EX-stage load
br_taken  in  1  branch/jump/JR resolved taken in EX this cycle
mem_cuDRE  in  1  MEM-stage read pending
mem_cuDWE  in  1  MEM-stage write pending
mem_HALT  in  1  halt instruction in MEM
pc_en  out  1  PC load enable
ifid_W  out  1  IF/ID write enable
ifid_RST  out  1  IF/ID synchronous flush (bubble)
idex_W  out  1  ID/EX write enable (idW)
idex_RST  out  1  ID/EX synchronous flush (idRST)
exmem_W  out  1  EX/MEM write enable
memwb_W  out  1  MEM/WB write enable
memwb_RST  out  1  MEM/WB bubble insert
halted  out  1  sticky halt flag
stall_cnt  out  CNT_W  cycles with pc_en=0
flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- Reset (nRST low, asynchronous):
  - state=RUN, halted=0, both counters=0.
  - Enable outputs are combinational from state and inputs, but are forced to all W=0 and all RST=0 while nRST is low.
- States:
  - RUN -> DWAIT when (mem_cuDRE|mem_cuDWE) & !dhit.
  - DWAIT -> RUN on dhit.
  - Any state -> HALT when mem_HALT & !(DWAIT & !dhit).
  - HALT is terminal until reset.
- Output decode, first matching row wins:
  1. HALT: all W=0, all RST=0, halted=1.
  2. Memory wait (DWAIT, or RUN with mem op & !dhit): pc_en=ifid_W=idex_W=exmem_W=0; memwb_W=1, memwb_RST=1, so WB sees a bubble.
  3. br_taken: pc_en=1, ifid_W=1, ifid_RST=1, idex_W=1, idex_RST=1, exmem_W=1, memwb_W=1. This applies regardless of ihit; the in-flight wrong-path fetch is abandoned. flush_cnt+1.
  4. Load-use, i.e. ex_cuDRE & ex_rt!=0 & (ex_rt==id_rsel1 | (id_rt_used & ex_rt==id_rsel2)): pc_en=0, ifid_W=0, idex_W=1, idex_RST=1, exmem_W=1, memwb_W=1. Lasts exactly one cycle; the next cycle the load has left EX.
  5. !ihit: pc_en=0, ifid_W=1, ifid_RST=1, remaining stages advance (W=1).
  6. Otherwise: all W=1, all RST=0.
- The dhit cycle that ends DWAIT is decoded as RUN with the wait cleared (rows 3-6 apply that cycle).
- stall_cnt increments on each cycle with pc_en=0 and state!=HALT. flush_cnt increments on row 3. Both saturate at all-ones and never wrap.
- Register $0 never causes a load-use stall.
- Latency: all control outputs are combinational, same cycle as the inputs. State and counters update on the CLK edge.

Decomposition:
- hzd_state_t enum (RUN, DWAIT, HALT) goes in cpu_types_pkg.
- Single module, no sub-module; the counters are inline always_ff blocks.

Test Plan:
- Reset released, ihit=1, no hazards -> all W=1, RST=0, counters 0.
- ex_cuDRE=1, ex_rt=8, id_rsel2=8, id_rt_used=1 -> one cycle with pc_en=0, ifid_W=0, idex_RST=1; stall_cnt=1; next cycle all W=1. Same stimulus with ex_rt=0 -> no stall.
- mem_cuDRE=1, dhit=0 for 3 cycles, then dhit=1 -> 3 cycles of frozen PC..EX/MEM with memwb_RST=1, advance on the 4th; stall_cnt=3.
- br_taken=1 with ihit=0 and a concurrent load-use match -> branch row wins: ifid_RST=idex_RST=1, pc_en=1; flush_cnt=1.
- mem_HALT=1 -> halted=1 next cycle and stays set; all W=0. Asserting nRST=0 mid-halt asynchronously clears halted and the counters.
- Force 2^CNT_W+5 stall cycles -> stall_cnt holds at 16'hFFFF.
